// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer-width helper, common to the single- and dual-clock FIFOs.
package fifo_pkg;

    localparam int FIFO_DEFAULT_WIDTH      = 32;
    localparam int FIFO_DEFAULT_DEPTH      = 8;
    localparam int FIFO_DEFAULT_ADDR_WIDTH = 3;

    // Pointers carry one extra wrap bit above the memory index.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port RAM, DEPTH x WIDTH. With FIFO_FWFT_EN defined the read port is
// asynchronous; otherwise the read word is registered and held between reads.
module fifo_mem_2p #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
`ifndef FIFO_FWFT_EN
    input  logic                  reset,
    input  logic                  rd_en,
`endif
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_data = mem_r[rd_addr];
`else
    logic [WIDTH-1:0] rd_data_r;

    // Registered read word: loads on an accepted pop, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with occupancy, almost-full/empty thresholds and sticky
// overflow/underflow. Define FIFO_FWFT_EN for first-word-fall-through reads.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH      = FIFO_DEFAULT_WIDTH,
    parameter int DEPTH      = FIFO_DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = FIFO_DEFAULT_ADDR_WIDTH,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      data_in,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      data_out,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int              PTR_W  = ptr_width(ADDR_WIDTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] AF_LVL  = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL  = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] count_s;
    logic             full_s;
    logic             empty_s;
    logic             wr_ok_s;
    logic             rd_ok_s;
    logic             overflow_r;
    logic             underflow_r;

    // Flags come straight from the registered pointers, so there is no extra flag latency.
    assign count_s = wr_ptr_r - rd_ptr_r;
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
                     (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]);

    // A full FIFO rejects the write even when a read is accepted in the same cycle.
    assign wr_ok_s = wr_en && !full_s;
    assign rd_ok_s = rd_en && !empty_s;

    // Write/read pointers; reset wins over any concurrent access.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_en && full_s) begin
                overflow_r <= 1'b1;
            end
            if (rd_en && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    fifo_mem_2p #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
`ifndef FIFO_FWFT_EN
        .reset   (reset),
        .rd_en   (rd_ok_s && !reset),
`endif
        .wr_en   (wr_ok_s && !reset),
        .wr_addr (wr_ptr_r[ADDR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr_r[ADDR_WIDTH-1:0]),
        .rd_data (data_out)
    );

    assign full         = full_s;
    assign empty        = empty_s;
    assign count        = count_s;
    assign almost_full  = (count_s >= AF_LVL);
    assign almost_empty = (count_s <= AE_LVL);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule
